// File: rtl/fetch_unit_n_pkg.sv
// Shared definitions for the N-wide fetch unit: word/step constants, the NOP
// encoding and helpers for packing per-lane 32-bit fields into flat vectors.
package fetch_unit_n_pkg;

  localparam int unsigned INSTR_W       = 32;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP           = 32'h0000_0000;

  // Low bit index of lane `lane` inside a flat WIDTH*INSTR_W vector.
  function automatic int unsigned lane_lo(input int unsigned lane);
    return lane * INSTR_W;
  endfunction

  // Byte address of lane `lane` relative to a fetch-group base (wraps mod 2^32).
  function automatic logic [31:0] lane_pc(input logic [31:0] base, input int unsigned lane);
    return base + PC_STEP * lane;
  endfunction

endpackage

// File: rtl/fetch_unit_n_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//   imem_addr/imem_data : WIDTH lanes of combinational-read instruction memory
//   deq_cnt             : number of instructions decode consumes this cycle
//   out_valid/out_instr/out_pc/out_pc_plus_4 : in-order decode window
//   q_count             : fetch queue occupancy
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_n_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 4
);
  logic [WIDTH*32-1:0] imem_addr;
  logic [WIDTH*32-1:0] imem_data;
  logic [CNT_W-1:0]    deq_cnt;
  logic [WIDTH-1:0]    out_valid;
  logic [WIDTH*32-1:0] out_instr;
  logic [WIDTH*32-1:0] out_pc;
  logic [WIDTH*32-1:0] out_pc_plus_4;
  logic [CNT_W-1:0]    q_count;

  modport master (
    output imem_addr,
    input  imem_data,
    input  deq_cnt,
    output out_valid,
    output out_instr,
    output out_pc,
    output out_pc_plus_4,
    output q_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output deq_cnt,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus_4,
    input  q_count
  );
endinterface

// File: rtl/fetch_unit_n_fetch_queue.sv
// Circular fetch queue: WIDTH-wide all-or-nothing push, WIDTH-wide read window
// starting at head, variable (clipped) dequeue and single-cycle flush.
// Ports: clk, rst_n (sync active-low), flush, push, push_instr/push_pc (lanes),
//        deq_cnt, rd_valid/rd_instr/rd_pc (window), count (occupancy).
// QDEPTH must be a power of two >= 2 so pointer wrap is plain overflow.
module fetch_queue
  import fetch_unit_n_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned QDEPTH = 8,
  parameter int unsigned CNT_W  = $clog2(QDEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH*INSTR_W-1:0] push_instr,
  input  logic [WIDTH*INSTR_W-1:0] push_pc,
  input  logic [CNT_W-1:0]         deq_cnt,
  output logic [WIDTH-1:0]         rd_valid,
  output logic [WIDTH*INSTR_W-1:0] rd_instr,
  output logic [WIDTH*INSTR_W-1:0] rd_pc,
  output logic [CNT_W-1:0]         count
);
  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W-1:0] PUSH_STEP = PTR_W'(WIDTH % QDEPTH);

  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d, eff;
  logic               push_ok;
  logic [INSTR_W-1:0] instr_q [QDEPTH];
  logic [INSTR_W-1:0] pc_q    [QDEPTH];

  always_comb begin
    push_ok = push & ~flush;
    // Over-dequeue is clipped to what is actually held.
    eff     = (deq_cnt > count_q) ? count_q : deq_cnt;
    head_d  = head_q + eff[PTR_W-1:0];
    tail_d  = push_ok ? tail_q + PUSH_STEP : tail_q;
    count_d = count_q + (push_ok ? CNT_W'(WIDTH) : '0) - eff;
    if (flush) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: unoccupied entries are masked on read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        instr_q[tail_q + PTR_W'(i)] <= push_instr[lane_lo(i) +: INSTR_W];
        pc_q[tail_q + PTR_W'(i)]    <= push_pc[lane_lo(i) +: INSTR_W];
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_rd
    assign rd_valid[i]                   = count_q > CNT_W'(i);
    assign rd_instr[lane_lo(i) +: INSTR_W] = rd_valid[i] ? instr_q[head_q + PTR_W'(i)] : NOP;
    assign rd_pc[lane_lo(i) +: INSTR_W]    = rd_valid[i] ? pc_q[head_q + PTR_W'(i)] : 32'h0;
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit_n.sv
// N-wide instruction fetch unit: owns the PC, drives WIDTH instruction-memory
// lanes, buffers fetched words in fetch_queue and presents up to WIDTH in-order
// instructions to decode. Handles redirect (flush + PC reload) and fetch stall.
// Ports: clk, rst_n (sync active-low), fetch_en, redirect_en, redirect_pc,
//        bus (fetch_unit_n_if.master: imem lanes, decode window, q_count).
module fetch_unit_n
  import fetch_unit_n_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = $clog2(QDEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  fetch_unit_n_if.master bus
);
  localparam logic [31:0] GROUP_STEP = PC_STEP * WIDTH;

  logic [31:0]              pc_q, pc_d;
  logic                     fetch;
  logic [CNT_W-1:0]         count;
  logic [WIDTH*INSTR_W-1:0] lane_addr;
  logic [WIDTH-1:0]         rd_valid;
  logic [WIDTH*INSTR_W-1:0] rd_instr, rd_pc, rd_pc_plus_4;

  // Space is judged on the registered count; same-cycle dequeue does not help.
  assign fetch = fetch_en & ~redirect_en & ((CNT_W'(QDEPTH) - count) >= CNT_W'(WIDTH));

  always_comb begin
    pc_d = pc_q;
    if (redirect_en) begin
      pc_d = redirect_pc & PC_ALIGN_MASK;
    end else if (fetch) begin
      pc_d = pc_q + GROUP_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign lane_addr[lane_lo(i) +: INSTR_W]    = lane_pc(pc_q, i);
    assign rd_pc_plus_4[lane_lo(i) +: INSTR_W] =
        rd_valid[i] ? rd_pc[lane_lo(i) +: INSTR_W] + PC_STEP : 32'h0;
  end

  fetch_queue #(
    .WIDTH  (WIDTH),
    .QDEPTH (QDEPTH),
    .CNT_W  (CNT_W)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_en),
    .push       (fetch),
    .push_instr (bus.imem_data),
    .push_pc    (lane_addr),
    .deq_cnt    (bus.deq_cnt),
    .rd_valid   (rd_valid),
    .rd_instr   (rd_instr),
    .rd_pc      (rd_pc),
    .count      (count)
  );

  assign bus.imem_addr     = lane_addr;
  assign bus.out_valid     = rd_valid;
  assign bus.out_instr     = rd_instr;
  assign bus.out_pc        = rd_pc;
  assign bus.out_pc_plus_4 = rd_pc_plus_4;
  assign bus.q_count       = count;

endmodule

// File: tb/tb_fetch_unit_n.sv
// Directed bench for fetch_unit_n (WIDTH=3, QDEPTH=8). Memory returns data = address.
// dut0 uses RESET_PC=0; dut1 shares stimulus with RESET_PC=0xFFFFFFF8 for PC wrap.
module tb_fetch_unit_n;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_unit_n_if #(.WIDTH(3), .CNT_W(4)) bus0 ();
  fetch_unit_n_if #(.WIDTH(3), .CNT_W(4)) bus1 ();

  assign bus0.imem_data = bus0.imem_addr;
  assign bus1.imem_data = bus1.imem_addr;

  fetch_unit_n #(.WIDTH(3), .QDEPTH(8), .RESET_PC(32'h0000_0000), .CNT_W(4)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .bus         (bus0)
  );

  fetch_unit_n #(.WIDTH(3), .QDEPTH(8), .RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .bus         (bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] p3(input logic [31:0] l0, input logic [31:0] l1,
                                     input logic [31:0] l2);
    return {l2, l1, l0};
  endfunction

  // Advance one rising edge, then sample 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic [3:0] d);
    rst_n         = r;
    fetch_en      = f;
    bus0.deq_cnt  = d;
    bus1.deq_cnt  = d;
  endtask

  initial begin
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    drive(1'b0, 1'b0, 4'd0);
    #1;

    // Reset state
    step();
    check("rst_qcount", bus0.q_count, 4'd0);
    check("rst_valid", bus0.out_valid, 3'b000);
    check("rst_addr0", bus0.imem_addr[31:0], 32'h0);

    // Fill / backpressure
    drive(1'b1, 1'b1, 4'd0);
    step();
    check("fill1_valid", bus0.out_valid, 3'b111);
    check("fill1_pc", bus0.out_pc, p3(32'h0, 32'h4, 32'h8));
    check("fill1_instr", bus0.out_instr, p3(32'h0, 32'h4, 32'h8));
    check("fill1_qcount", bus0.q_count, 4'd3);
    step();
    check("fill2_qcount", bus0.q_count, 4'd6);
    step();
    check("full_qcount", bus0.q_count, 4'd6);
    check("full_addr0", bus0.imem_addr[31:0], 32'h18);
    check("full_addr2", bus0.imem_addr[95:64], 32'h20);

    // Partial dequeue
    drive(1'b1, 1'b0, 4'd1);
    step();
    check("deq1_pc", bus0.out_pc, p3(32'h4, 32'h8, 32'hC));
    check("deq1_qcount", bus0.q_count, 4'd5);
    drive(1'b1, 1'b0, 4'd2);
    step();
    check("deq2_pc", bus0.out_pc, p3(32'hC, 32'h10, 32'h14));
    check("deq2_qcount", bus0.q_count, 4'd3);

    // Steady stream from a fresh reset
    drive(1'b0, 1'b0, 4'd0);
    step();
    check("rst2_valid", bus0.out_valid, 3'b000);
    drive(1'b1, 1'b1, 4'd3);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] b;
      b = 32'hC * k;
      step();
      check("stream_qcount", bus0.q_count, 4'd3);
      check("stream_pc", bus0.out_pc, p3(b, b + 32'h4, b + 32'h8));
      check("stream_instr", bus0.out_instr, p3(b, b + 32'h4, b + 32'h8));
    end

    // Redirect with a full-ish queue and a pending dequeue
    drive(1'b1, 1'b1, 4'd0);
    step();
    check("pre_redir_qcount", bus0.q_count, 4'd6);
    redirect_en = 1'b1;
    redirect_pc = 32'h1003;
    drive(1'b1, 1'b1, 4'd3);
    step();
    check("redir_valid", bus0.out_valid, 3'b000);
    check("redir_qcount", bus0.q_count, 4'd0);
    check("redir_addr0", bus0.imem_addr[31:0], 32'h1000);
    check("redir_pc_zero", bus0.out_pc, 96'h0);
    redirect_en = 1'b0;
    drive(1'b1, 1'b1, 4'd0);
    step();
    check("tgt_pc", bus0.out_pc, p3(32'h1000, 32'h1004, 32'h1008));
    check("tgt_pc4", bus0.out_pc_plus_4, p3(32'h1004, 32'h1008, 32'h100C));
    check("tgt_valid", bus0.out_valid, 3'b111);

    // Over-dequeue: bring count to 2, then ask for 3
    drive(1'b1, 1'b0, 4'd1);
    step();
    check("two_valid", bus0.out_valid, 3'b011);
    check("two_pc", bus0.out_pc, p3(32'h1004, 32'h1008, 32'h0));
    check("two_pc4_lane2", bus0.out_pc_plus_4[95:64], 32'h0);
    drive(1'b1, 1'b0, 4'd3);
    step();
    check("over_qcount", bus0.q_count, 4'd0);
    check("over_valid", bus0.out_valid, 3'b000);
    check("stall_addr0", bus0.imem_addr[31:0], 32'h100C);
    drive(1'b1, 1'b1, 4'd0);
    step();
    check("after_over_pc", bus0.out_pc, p3(32'h100C, 32'h1010, 32'h1014));
    check("after_over_qcount", bus0.q_count, 4'd3);

    // Reset mid-run (redirect asserted too; reset must win), then PC wrap
    step();
    check("mid_qcount", bus0.q_count, 4'd6);
    redirect_en = 1'b1;
    redirect_pc = 32'h2000;
    drive(1'b0, 1'b1, 4'd0);
    step();
    check("mid_rst_valid", bus0.out_valid, 3'b000);
    check("mid_rst_qcount", bus0.q_count, 4'd0);
    check("mid_rst_addr0", bus0.imem_addr[31:0], 32'h0);
    check("wrap_rst_addr0", bus1.imem_addr[31:0], 32'hFFFF_FFF8);
    check("wrap_rst_addr2", bus1.imem_addr[95:64], 32'h0);
    redirect_en = 1'b0;
    drive(1'b1, 1'b1, 4'd0);
    step();
    check("post_rst_pc", bus0.out_pc, p3(32'h0, 32'h4, 32'h8));
    check("wrap_pc", bus1.out_pc, p3(32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0));
    check("wrap_pc4", bus1.out_pc_plus_4, p3(32'hFFFF_FFFC, 32'h0, 32'h4));
    check("wrap_addr0", bus1.imem_addr[31:0], 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit_n.md
Name: fetch_unit_n

Overview:
Parametrised N-wide instruction fetch unit, the successor to the fixed 3-lane fetch stage. It owns the PC register and drives WIDTH combinational-read instruction-memory ports. Fetched words are buffered in a circular fetch queue, and up to WIDTH in-order instructions per cycle are presented to decode with variable-count dequeue. It also handles redirect (branch/jump) with queue flush, and fetch stall.

Parameters:
WIDTH, 3, fetch/issue lanes per cycle (1..4)
QDEPTH, 8, fetch queue entries; power of two, at least WIDTH
RESET_PC, 32'h00000000, PC loaded on reset
CNT_W, $clog2(QDEPTH+1), width of the count and dequeue fields (derived)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
fetch_en  in  1  fetch enable; low = stall fetch, PC holds
redirect_en  in  1  branch/jump taken; flush and reload PC
redirect_pc  in  32  redirect target (byte address)
imem_addr  out  WIDTH*32  lane i address = pc + 4*i (combinational)
imem_data  in  WIDTH*32  lane i instruction word, same-cycle (async SRAM read)
deq_cnt  in  CNT_W  instructions consumed this cycle from lanes 0..deq_cnt-1
out_valid  out  WIDTH  bit i = queue count > i
out_instr  out  WIDTH*32  queue entry head+i
out_pc  out  WIDTH*32  PC of entry head+i
out_pc_plus_4  out  WIDTH*32  out_pc lane i + 4 (link/branch base)
q_count  out  CNT_W  current queue occupancy

Behaviour:
- Reset (rst_n low at posedge): pc<=RESET_PC; head, tail, count<=0. Next cycle: out_valid=0, q_count=0. Reset dominates redirect, fetch and dequeue. Reset mid-operation discards all queued entries.
- Fetch condition: fetch_en & !redirect_en & (QDEPTH - count >= WIDTH). Count is the registered pre-dequeue value; same-cycle dequeue does not free space for fetch.
- On fetch: entry tail+i <= {imem_data lane i, pc+4i} for all lanes; tail += WIDTH mod QDEPTH; pc <= pc + 4*WIDTH.
- Fetch is all-or-nothing; there are no partial-width fetches.
- Latency: a word fetched at edge k is visible on out_* after edge k, i.e. 1 cycle from address to out_valid.
- Dequeue: eff = min(deq_cnt, count); head += eff mod QDEPTH. deq_cnt > count is clipped, with no underflow and no error.
- count_next = count + (fetch ? WIDTH : 0) - eff. Simultaneous fetch and dequeue are both applied.
- Redirect (redirect_en high, rst_n high): queue flushed (head=tail, count=0); deq_cnt ignored; no fetch that cycle; pc <= {redirect_pc[31:2], 2'b00}, so misaligned low bits are dropped.
- After a redirect, out_valid=0 for one cycle. The target words appear the cycle after that if fetch_en is high.
- PC arithmetic is 32-bit modulo; wrap past 32'hFFFFFFFC continues at 0. out_pc_plus_4 wraps identically.
- Outputs are driven purely from registered state (head, count, queue), except imem_addr, which is combinational from pc.
- Lanes with out_valid=0 drive zero instr/pc.

Decomposition:
- Shared package: INSTR_W=32, PC_STEP=4, PC_ALIGN_MASK, NOP encoding (32'h0), and the lane pack/unpack index helpers.
- Sub-module fetch_queue: circular buffer with WIDTH-wide write, WIDTH-wide read window, variable dequeue, flush, and count output.
- fetch_unit_n holds the PC register, fetch/redirect control and lane PC adders.

Test Plan:
All scenarios use WIDTH=3, QDEPTH=8, RESET_PC=0, and a memory model returning data = address.
1. Fill/backpressure: reset, then fetch_en=1, deq_cnt=0 → after edge 1, out_valid=111, out_pc=0,4,8, q_count=3. After edge 2, q_count=6. After edge 3, no fetch (free 2<3): q_count=6, imem_addr lane0 stays 0x18.
2. Steady stream: deq_cnt=3 every cycle from reset → q_count holds 3; out_pc advances 0x0→0xC→0x18 per cycle; out_instr equals out_pc on each lane.
3. Partial dequeue: q_count=6 (pcs 0..0x14), fetch_en=0, deq_cnt=1 → out_pc=4,8,C, q_count=5. Then deq_cnt=2 → out_pc=0xC,0x10,0x14.
4. Redirect: q_count=6, redirect_en=1, redirect_pc=0x1003, deq_cnt=3 → next cycle out_valid=000, q_count=0, imem_addr lane0=0x1000. Following cycle out_pc=0x1000,0x1004,0x1008, out_pc_plus_4 lane2=0x100C.
5. Over-dequeue: q_count=2, fetch_en=0, deq_cnt=3 → q_count=0, out_valid=000. Head and tail stay consistent: a later fetch yields correct pcs.
6. Reset mid-run and wrap: q_count=6, rst_n=0 for one edge → out_valid=000, imem_addr lane0=RESET_PC. With RESET_PC=0xFFFFFFF8: out_pc=0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
